// File: rtl/binary_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module   : binary_pattern_pkg
// Brief    : Shared types and helpers for the binary pattern generator.
//            The optional ONES/WALK0 phases are selected by the macro
//            BINARY_PATTERN_GEN_WALK_ZERO_EN.
// Revision : 1.0 - initial release
// ============================================================================
package binary_pattern_pkg;

    // Default word width of the detector stream.
    localparam int DEFAULT_WIDTH = 64;

    // Build-time flag mirroring the optional walking-zero phases.
`ifdef BINARY_PATTERN_GEN_WALK_ZERO_EN
    localparam bit WALK_ZERO_EN = 1'b1;
`else
    localparam bit WALK_ZERO_EN = 1'b0;
`endif

    // Sequencer states. ONES and WALK0 are only reachable when the
    // walking-zero phases are compiled in.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ZERO  = 3'd1,
        WALK1 = 3'd2,
        ONES  = 3'd3,
        WALK0 = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Number of words in one complete sequence.
    function automatic int seq_len(input int width, input bit walk_zero);
        return walk_zero ? (2 * width + 2) : (width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/binary_pattern_generator_if.sv
`default_nettype none
// ============================================================================
// Module   : binary_pattern_generator_if
// Brief    : Request and valid/ready word stream between the pattern
//            generator (master) and its consumer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface binary_pattern_generator_if
    import binary_pattern_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             done;

    modport master (
        input  start,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_last,
        output busy,
        output done
    );

    modport slave (
        output start,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  busy,
        input  done
    );
endinterface
`default_nettype wire

// File: rtl/pattern_word_builder.sv
`default_nettype none
// ============================================================================
// Module   : pattern_word_builder
// Brief    : Combinational map from (state, idx) to the test word and the
//            final-word flag. Honours BINARY_PATTERN_GEN_WALK_ZERO_EN: with
//            it, the last word is the final walking zero; without it, the
//            final walking one.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_word_builder
    import binary_pattern_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  state_t           i_state,
    input  logic [IDX_W-1:0] i_idx,
    output logic [WIDTH-1:0] o_word,
    output logic             o_last
);

    localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(WIDTH - 1);

    // Select the word for the current phase; ZERO, IDLE and DONE give 0.
    always_comb begin
        o_word = '0;
        o_last = 1'b0;
        case (i_state)
            WALK1: begin
                o_word = c_ONE << i_idx;
`ifndef BINARY_PATTERN_GEN_WALK_ZERO_EN
                o_last = (i_idx == c_IDX_LAST);
`endif
            end
`ifdef BINARY_PATTERN_GEN_WALK_ZERO_EN
            ONES: begin
                o_word = '1;
            end
            WALK0: begin
                o_word = ~(c_ONE << i_idx);
                o_last = (i_idx == c_IDX_LAST);
            end
`endif
            default: begin
                o_word = '0;
                o_last = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/binary_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module   : binary_pattern_generator
// Brief    : On request emits all-zero followed by a walking one (and, with
//            BINARY_PATTERN_GEN_WALK_ZERO_EN defined, all-ones followed by a
//            walking zero) over a valid/ready stream, then pulses done.
//            All outputs are registered from the next-state values, so no
//            input reaches an output combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module binary_pattern_generator
    import binary_pattern_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    binary_pattern_generator_if.master bus
);

    localparam int                 c_IDX_W    = $clog2(WIDTH);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WIDTH - 1);

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   w_idx_nxt;

    logic                 r_valid;
    logic [WIDTH-1:0]     r_data;
    logic                 r_last;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_xfer;
    logic [WIDTH-1:0]     w_word_nxt;
    logic                 w_last_nxt;
    logic                 w_valid_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;

    // A word moves only while it is actually presented.
    assign w_xfer = r_valid & bus.out_ready;

    // State and index register; reset aborts any sequence in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state and index logic; the terminal compare precedes any wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ZERO;
                    w_idx_nxt   = '0;
                end
            end
            ZERO: begin
                if (w_xfer) begin
                    w_state_nxt = WALK1;
                    w_idx_nxt   = '0;
                end
            end
            WALK1: begin
                if (w_xfer) begin
                    if (r_idx == c_IDX_LAST) begin
`ifdef BINARY_PATTERN_GEN_WALK_ZERO_EN
                        w_state_nxt = ONES;
`else
                        w_state_nxt = DONE;
`endif
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                    end
                end
            end
`ifdef BINARY_PATTERN_GEN_WALK_ZERO_EN
            ONES: begin
                if (w_xfer) begin
                    w_state_nxt = WALK0;
                    w_idx_nxt   = '0;
                end
            end
            WALK0: begin
                if (w_xfer) begin
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = DONE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                    end
                end
            end
`endif
            DONE: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Word and last flag for the state about to be entered.
    pattern_word_builder #(
        .WIDTH (WIDTH),
        .IDX_W (c_IDX_W)
    ) u_word_builder (
        .i_state (w_state_nxt),
        .i_idx   (w_idx_nxt),
        .o_word  (w_word_nxt),
        .o_last  (w_last_nxt)
    );

    // Output decode from the next state, so registered outputs line up with it.
    always_comb begin
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (w_state_nxt)
            IDLE: begin
                w_valid_nxt = 1'b0;
            end
            DONE: begin
                w_busy_nxt  = 1'b1;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_data  <= w_word_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_last  = r_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: doc/binary_pattern_generator.md
# binary_pattern_generator

Sequential stimulus source for the binary detector family: on request it emits a fixed sequence of WIDTH-bit test words (all-zero, then a walking one) over a valid/ready stream. The detectors consume this stream and flag the bits they see. It is the producing end of the same 64-bit word interface and is intended for self-test and bring-up of the detectors.

## Interface
- WIDTH, 64, word width; must be at least 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  sequence request; sampled only in IDLE.
- out_ready  input  1  consumer accepts the current word.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  WIDTH  current test word.
- out_last  output  1  qualifies the final word of the sequence.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse after the last transfer.

## Operation
- States: IDLE, ZERO, WALK1, ONES (macro only), WALK0 (macro only), DONE.
- IDLE with start=1 -> ZERO. start in any other state is ignored.
- ZERO: out_data = 0. Transfer -> WALK1 with idx = 0.
- WALK1: out_data = 1 << idx. On transfer, idx increments. Transfer at idx = WIDTH-1 -> DONE (or -> ONES with the macro).
- ONES: out_data is all ones. Transfer -> WALK0 with idx = 0.
- WALK0: out_data = ~(1 << idx). Transfer at idx = WIDTH-1 -> DONE.
- DONE: out_valid = 0, done = 1, busy = 1 for exactly one cycle, then -> IDLE.
- A transfer occurs on a rising edge where out_valid & out_ready are both 1.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable and the state does not advance.
- out_valid is high in every non-IDLE, non-DONE state.
- out_last is high only on the final word: WALK1 at idx = WIDTH-1 without the macro, WALK0 at idx = WIDTH-1 with it.
- idx has $clog2(WIDTH) bits. It is never incremented past WIDTH-1; the terminal compare happens before any wrap.
- Sequence length: WIDTH+1 words (65 at default), or 2*WIDTH+2 words with the macro (130 at default).

## Timing
- Reset (rst_n low at an edge) forces IDLE and idx = 0. All outputs are 0 after that edge: out_valid, out_data, out_last, busy, done.
- Reset mid-sequence aborts the sequence immediately. No done pulse is issued and no partial completion occurs.
- start accepted at edge N: out_valid = 1 and out_data = 0 from N+1.
- With out_ready held high, one word transfers per cycle and there are no bubbles between states.
- Full sequence at default WIDTH with constant ready: 65 cycles of valid, then 1 DONE cycle.
- done rises on the edge after the out_last transfer, lasts one cycle, and busy falls with it.
- Earliest restart: start sampled in the first IDLE cycle after DONE.
- out_ready is ignored when out_valid=0.
- All outputs are registered. There is no combinational path from start or out_ready to any output.

## Configuration
- BINARY_PATTERN_GEN_WALK_ZERO_EN defined: the ONES and WALK0 phases are compiled in, giving the 2*WIDTH+2 word sequence.
- Undefined: ONES and WALK0 are absent. WALK1 at WIDTH-1 goes directly to DONE, and out_last is set on that word.

## Structure
- Package binary_pattern_pkg:
  - state enum (IDLE, ZERO, WALK1, ONES, WALK0, DONE).
  - DEFAULT_WIDTH = 64.
  - function seq_len(width, walk_zero) returning the word count.
- Sub-module pattern_word_builder: combinational. Maps (state, idx) to the WIDTH-bit word and the out_last flag. The top level registers its output.
- Top level contains the FSM, the idx counter and the output registers.

## Test plan
- Reset then idle: rst_n = 0 for 2 cycles, then 1 -> all outputs 0. start = 0 for 10 cycles -> out_valid stays 0.
- Full sweep (WIDTH=64, macro off, out_ready = 1):
  - start pulse -> 65 consecutive words: 0, 0x1, 0x2, ... 0x8000_0000_0000_0000.
  - out_last only on the 65th word.
  - done one cycle later.
- Backpressure: out_ready = 0 for 5 cycles while word 0x10 is presented -> word holds 0x10 and the state is frozen. Release -> next word is 0x20.
- start during busy: pulse start at word 10 -> no effect; the sequence still totals 65 words with a single done.
- Reset mid-sequence: rst_n = 0 at word 30 -> next cycle all outputs 0 and no done. A new start produces word 0 first.
- Macro on: 130 words.
  - Word 65 is 0xFFFF_FFFF_FFFF_FFFF.
  - Word 66 is 0xFFFF_FFFF_FFFF_FFFE.
  - Last word is 0x7FFF_FFFF_FFFF_FFFF, with out_last set.
